// File: rtl/project_pkg.sv
// Shared types for the matrix UART path: the command bundle handed to the
// sender and the fixed requester indices.
package project_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] matrix_element_t;

  typedef struct packed {
    matrix_element_t data;
    logic            is_last_col;
    logic            newline_only;
    logic            id;
    logic            sum_head;
    logic            sum_elem;
  } sender_cmd_t;

  localparam int REQ_DISPLAY = 0;
  localparam int REQ_CALC    = 1;
  localparam int REQ_MSG     = 2;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and sender-side handshake bundle around the UART arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if
  import project_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic        [NUM_REQ-1:0] req;
  sender_cmd_t [NUM_REQ-1:0] req_cmd;
  logic        [NUM_REQ-1:0] req_start;
  logic        [NUM_REQ-1:0] grant;
  logic        [NUM_REQ-1:0] req_ready;
  logic        [NUM_REQ-1:0] req_done;
  sender_cmd_t               sender_cmd;
  logic                      sender_start;
  logic                      sender_ready;
  logic                      sender_done;

  modport slave (
    input  req, req_cmd, req_start, sender_ready, sender_done,
    output grant, req_ready, req_done, sender_cmd, sender_start
  );

  modport master (
    output req, req_cmd, req_start, sender_ready, sender_done,
    input  grant, req_ready, req_done, sender_cmd, sender_start
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin search: first set request bit strictly after `last`, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   last,
  output logic               found,
  output logic [OWN_W-1:0]   idx
);

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    logic [OWN_W-1:0] cand;
    cand  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = OWN_W'((int'(last) + k) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Session-level round-robin owner of the shared matrix_uart_sender; muxes the
// owner's command onto the sender and flags starts that cannot be honoured.
module uart_tx_arbiter
  import project_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus,
  output logic [OWN_W-1:0]   owner,
  output logic               busy,
  output logic               violation
);

  typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

  state_t             state;
  logic [OWN_W-1:0]   last;
  logic [OWN_W-1:0]   pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_pick (
    .req   (bus.req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A start is only legal from the granted owner while the sender is idle.
  assign accept = grant & {NUM_REQ{bus.sender_ready}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= OWN_W'(NUM_REQ - 1);
      grant     <= '0;
      violation <= 1'b0;
    end else begin
      violation <= |(bus.req_start & ~accept);
      case (state)
        IDLE: begin
          if (pick_found && bus.sender_ready) begin
            state <= OWNED;
            owner <= pick_idx;
            last  <= pick_idx;
            grant <= NUM_REQ'(1) << pick_idx;
          end
        end
        OWNED: begin
          if (!bus.req[owner]) begin
            grant <= '0;
            state <= bus.sender_ready ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (bus.sender_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy             = (state != IDLE);
  assign bus.grant        = grant;
  assign bus.req_ready    = accept;
  assign bus.sender_start = bus.req_start[owner] & accept[owner];

  // The draining owner still hears its final sender_done.
  always_comb begin
    bus.req_done   = '0;
    bus.sender_cmd = '0;
    if (busy) begin
      bus.req_done[owner] = bus.sender_done;
      bus.sender_cmd      = bus.req_cmd[owner];
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed session scenarios with literal checks,
// then random traffic compared every cycle against a session-level model.
module tb_uart_tx_arbiter;
  import project_pkg::*;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] owner;
  logic       busy;
  logic       violation;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .owner     (owner),
    .busy      (busy),
    .violation (violation)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Session model: who holds the sender, whether that session is only waiting
  // for the last transfer, and who was served most recently.
  int m_owner = -1;
  bit m_drain = 1'b0;
  int m_last  = N - 1;
  bit m_viol  = 1'b0;

  function automatic int next_owner(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++)
      if (r[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  function automatic bit bad_start(input logic [N-1:0] s, input int own, input bit drn, input logic rdy);
    for (int i = 0; i < N; i++)
      if (s[i] && !(i == own && !drn && rdy)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1;
      m_drain <= 1'b0;
      m_last  <= N - 1;
      m_viol  <= 1'b0;
    end else begin
      m_viol <= bad_start(bus.req_start, m_owner, m_drain, bus.sender_ready);
      if (m_owner < 0) begin
        if (bus.sender_ready && next_owner(bus.req, m_last) >= 0) begin
          m_owner <= next_owner(bus.req, m_last);
          m_last  <= next_owner(bus.req, m_last);
        end
      end else if (!m_drain) begin
        if (!bus.req[m_owner]) begin
          if (bus.sender_ready) m_owner <= -1;
          else                  m_drain <= 1'b1;
        end
      end else if (bus.sender_ready) begin
        m_owner <= -1;
        m_drain <= 1'b0;
      end
    end
  end

  function automatic logic [N-1:0] exp_grant();
    return (m_owner >= 0 && !m_drain) ? N'(1) << m_owner : '0;
  endfunction

  function automatic logic [N-1:0] exp_done();
    return (m_owner >= 0) ? N'(bus.sender_done) << m_owner : '0;
  endfunction

  function automatic logic [31:0] exp_cmd();
    return (m_owner >= 0) ? 32'(bus.req_cmd[m_owner]) : 32'd0;
  endfunction

  function automatic logic exp_start();
    return (m_owner >= 0) && !m_drain && bus.sender_ready && bus.req_start[m_owner];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_grant",     32'(bus.grant),        32'(exp_grant()));
      check("m_req_ready", 32'(bus.req_ready),    32'(exp_grant() & {N{bus.sender_ready}}));
      check("m_req_done",  32'(bus.req_done),     32'(exp_done()));
      check("m_cmd",       32'(bus.sender_cmd),   exp_cmd());
      check("m_start",     32'(bus.sender_start), 32'(exp_start()));
      check("m_busy",      32'(busy),             32'(m_owner >= 0));
      check("m_violation", 32'(violation),        32'(m_viol));
      if (m_owner >= 0) check("m_owner", 32'(owner), 32'(m_owner));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"},     32'(bus.grant),        32'd0);
    check({tag, "_req_ready"}, 32'(bus.req_ready),    32'd0);
    check({tag, "_req_done"},  32'(bus.req_done),     32'd0);
    check({tag, "_start"},     32'(bus.sender_start), 32'd0);
    check({tag, "_busy"},      32'(busy),             32'd0);
    check({tag, "_violation"}, 32'(violation),        32'd0);
    check({tag, "_owner"},     32'(owner),            32'd0);
    check({tag, "_cmd"},       32'(bus.sender_cmd),   32'd0);
  endtask

  initial begin
    logic [20:0] rnd;
    bus.req          = '0;
    bus.req_start    = '0;
    bus.sender_ready = 1'b1;
    bus.sender_done  = 1'b0;
    for (int i = 0; i < N; i++) bus.req_cmd[i] = '0;

    cyc(2);
    rst    = 1'b0;
    chk_en = 1'b1;
    #3 check_reset_values("rst");

    // single requester, three transfers of value 5
    cyc(); bus.req = 3'b001;
    #3 check("single_grant_t0", 32'(bus.grant), 32'h0);
    cyc();
    #3 check("single_grant_t1", 32'(bus.grant), 32'h1);
    for (int n = 0; n < 3; n++) begin
      cyc(); bus.req_cmd[0].data = 16'sd5; bus.req_start = 3'b001;
      #3 check("single_start", 32'(bus.sender_start), 32'h1);
      check("single_data", 32'(bus.sender_cmd.data), 32'h5);
      cyc(); bus.req_start = '0; bus.sender_done = 1'b1;
      #3 check("single_done", 32'(bus.req_done), 32'h1);
      cyc(); bus.sender_done = 1'b0;
    end
    cyc(); bus.req = '0;
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; bus.req = 3'b111;

    // simultaneous requests served 0,1,2 with two-cycle handovers
    cyc();
    #3 check("simul_first", 32'(bus.grant), 32'h1);
    for (int n = 0; n < 3; n++) begin
      cyc(); bus.req_start = 3'(1 << n);
      #3 check("simul_start", 32'(bus.sender_start), 32'h1);
      cyc(); bus.req_start = '0; bus.sender_done = 1'b1;
      #3 check("simul_done", 32'(bus.req_done), 32'(1 << n));
      cyc(); bus.sender_done = 1'b0; bus.req[n] = 1'b0;
      #3 check("simul_hold", 32'(bus.grant), 32'(1 << n));
      cyc();
      #3 check("simul_gap", 32'(bus.grant), 32'h0);
      cyc();
      #3 check("simul_next", 32'(bus.grant), (n < 2) ? 32'(1 << (n + 1)) : 32'h0);
    end

    // owner 1 holds while 0 and 2 wait
    cyc(); bus.req = 3'b010;
    cyc();
    #3 check("np_grant", 32'(bus.grant), 32'h2);
    bus.req = 3'b111;
    for (int n = 0; n < 50; n++) begin
      cyc();
      #3 check("np_hold", 32'(bus.grant), 32'h2);
    end
    cyc(); bus.req = 3'b101;
    cyc(); #3 check("np_gap", 32'(bus.grant), 32'h0);
    cyc(); #3 check("np_to2", 32'(bus.grant), 32'h4);
    cyc(); bus.req = 3'b001;
    cyc(); #3 check("np_gap2", 32'(bus.grant), 32'h0);
    cyc(); #3 check("np_to0", 32'(bus.grant), 32'h1);

    // owner leaves while the sender is still busy
    cyc(); bus.sender_ready = 1'b0; bus.req = 3'b100;
    #3 check("drain_pre", 32'(bus.grant), 32'h1);
    check("drain_pre_ready", 32'(bus.req_ready), 32'h0);
    cyc();
    #3 check("drain_grant", 32'(bus.grant), 32'h0);
    check("drain_busy", 32'(busy), 32'h1);
    check("drain_owner", 32'(owner), 32'h0);
    cyc(); bus.sender_done = 1'b1;
    #3 check("drain_done", 32'(bus.req_done), 32'h1);
    cyc(); bus.sender_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc();
      #3 check("drain_wait", 32'(bus.grant), 32'h0);
      check("drain_wait_busy", 32'(busy), 32'h1);
    end
    cyc(); bus.sender_ready = 1'b1;
    cyc(); #3 check("drain_idle", 32'(busy), 32'h0);
    cyc(); #3 check("drain_next", 32'(bus.grant), 32'h4);

    // start from a non-owner
    cyc(); bus.req = 3'b001;
    cyc(); #3 check("viol_gap", 32'(bus.grant), 32'h0);
    cyc(); #3 check("viol_own0", 32'(bus.grant), 32'h1);
    cyc(); bus.req_start = 3'b100;
    #3 check("viol_nostart", 32'(bus.sender_start), 32'h0);
    check("viol_early", 32'(violation), 32'h0);
    cyc(); bus.req_start = '0;
    #3 check("viol_pulse", 32'(violation), 32'h1);
    check("viol_owner", 32'(owner), 32'h0);
    check("viol_grant", 32'(bus.grant), 32'h1);
    cyc();
    #3 check("viol_clear", 32'(violation), 32'h0);

    // reset in the middle of a session, sender not yet idle
    cyc(); bus.sender_ready = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    #3 check_reset_values("midrst");
    for (int n = 0; n < 5; n++) begin
      cyc();
      #3 check("midrst_hold", 32'(bus.grant), 32'h0);
    end
    cyc(); bus.sender_ready = 1'b1;
    cyc(); #3 check("midrst_regrant", 32'(bus.grant), 32'h1);

    // random traffic against the model
    cyc(); bus.req = '0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) bus.req[i] = ~bus.req[i];
        rnd = 21'($urandom);
        bus.req_cmd[i] = rnd;
      end
      bus.req_start    = 3'($urandom) & 3'($urandom) & 3'($urandom);
      bus.sender_ready = ($urandom_range(0, 3) != 0);
      bus.sender_done  = ($urandom_range(0, 5) == 0);
      rst              = ($urandom_range(0, 199) == 0);
    end
    cyc();
    rst = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
